fifo_to_pcap_mem_writer: RTL and testbench

//  Read side of the packed AXIS->FIFO path. Drains 144-bit packed words, i.e. 16 lanes of {mark,byte[7:0]}, plus a per-word queue id.

---
 rtl/fifo_to_pcap_mem_writer_if.sv | 26 ++
 rtl/fifo_to_pcap_mem_writer.sv | 168 ++++++++++++++++
 tb/tb_fifo_to_pcap_mem_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_to_pcap_mem_writer_if.sv
// FIFO read port and memory write port of the pcap memory writer, bundled so that
// the writer and its environment see matching directions.
interface fifo_to_pcap_mem_writer_if #(
    parameter int unsigned FIFO_DATA_WIDTH = 144,
    parameter int unsigned NUM_QUEUES_BITS = 2,
    parameter int unsigned QUEUE_ADDR_BITS = 19
);
    logic [FIFO_DATA_WIDTH-1:0]                 fifo_dout;
    logic [NUM_QUEUES_BITS-1:0]                 fifo_dout_qid;
    logic                                       fifo_empty;
    logic                                       fifo_rd_en;
    logic                                       mem_wr_valid;
    logic                                       mem_wr_ready;
    logic [NUM_QUEUES_BITS+QUEUE_ADDR_BITS-1:0] mem_wr_addr;
    logic [FIFO_DATA_WIDTH-1:0]                 mem_wr_data;

    modport master (
        input  fifo_dout, fifo_dout_qid, fifo_empty, mem_wr_ready,
        output fifo_rd_en, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output fifo_dout, fifo_dout_qid, fifo_empty, mem_wr_ready,
        input  fifo_rd_en, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/fifo_to_pcap_mem_writer.sv
// Drains packed {mark,byte} FIFO words, frames them into packets and stores each packet
// in a per-queue region of the replay memory, keeping per-queue pointers and counters.
module fifo_to_pcap_mem_writer #(
    parameter int unsigned FIFO_DATA_WIDTH = 144,
    parameter int unsigned NUM_QUEUES      = 4,
    parameter int unsigned NUM_QUEUES_BITS = 2,
    parameter int unsigned QUEUE_ADDR_BITS = 19,
    parameter int unsigned MAX_PKT_WORDS   = 128
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_aresetn,
    input  logic                                  sw_rst,
    fifo_to_pcap_mem_writer_if.master             bus,
    output logic [NUM_QUEUES*QUEUE_ADDR_BITS-1:0] q_wr_ptr,
    output logic [NUM_QUEUES*32-1:0]              q_pkt_cnt,
    output logic [NUM_QUEUES*32-1:0]              q_drop_cnt
);
    localparam int unsigned Lanes = FIFO_DATA_WIDTH / 9;
    localparam int unsigned CntW  = $clog2(MAX_PKT_WORDS + 1);
    localparam int unsigned AddrW = NUM_QUEUES_BITS + QUEUE_ADDR_BITS;

    localparam logic [2:0] StHdr0  = 3'd0;
    localparam logic [2:0] StHdr1  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StPad   = 3'd3;
    localparam logic [2:0] StDropH = 3'd4;
    localparam logic [2:0] StDrop  = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic                       parity_q, parity_d;
    logic [NUM_QUEUES_BITS-1:0] qid_q, qid_d;
    logic [CntW-1:0]            wcnt_q, wcnt_d;
    logic [QUEUE_ADDR_BITS-1:0] ptr_q [NUM_QUEUES];
    logic [QUEUE_ADDR_BITS-1:0] ptr_d [NUM_QUEUES];
    logic [31:0]                pkt_cnt_q [NUM_QUEUES];
    logic [31:0]                pkt_cnt_d [NUM_QUEUES];
    logic [31:0]                drop_cnt_q [NUM_QUEUES];
    logic [31:0]                drop_cnt_d [NUM_QUEUES];
    logic                       wr_valid_q, wr_valid_d;
    logic [AddrW-1:0]           wr_addr_q, wr_addr_d;
    logic [FIFO_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                       rst_act, eop, need_slot, slot_free, pop, do_write, hdr_fits;
    logic [NUM_QUEUES_BITS-1:0] wr_qid;
    logic [QUEUE_ADDR_BITS:0]   free_words;

    assign rst_act = !axi_aresetn || sw_rst;

    always_comb begin
        eop = 1'b0;
        for (int i = 0; i < Lanes; i++) begin
            eop = eop | bus.fifo_dout[9*i+8];
        end
    end

    // Only header and body words need the output slot; discarded words drain freely.
    assign need_slot      = (state_q == StHdr0) || (state_q == StData);
    assign slot_free      = !wr_valid_q || bus.mem_wr_ready;
    assign pop            = !bus.fifo_empty && !rst_act && (!need_slot || slot_free);
    assign bus.fifo_rd_en = pop;

    assign wr_qid     = (state_q == StHdr0) ? bus.fifo_dout_qid : qid_q;
    assign free_words = {1'b1, {QUEUE_ADDR_BITS{1'b0}}} - {1'b0, ptr_q[bus.fifo_dout_qid]};
    assign hdr_fits   = 32'(free_words) >= MAX_PKT_WORDS;

    always_comb begin
        state_d    = state_q;
        parity_d   = parity_q;
        qid_d      = qid_q;
        wcnt_d     = wcnt_q;
        ptr_d      = ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        do_write   = 1'b0;
        wr_valid_d = wr_valid_q && !bus.mem_wr_ready;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (pop) begin
            parity_d = !parity_q;
            unique case (state_q)
                StHdr0: begin
                    qid_d = bus.fifo_dout_qid;
                    if (hdr_fits) begin
                        do_write = 1'b1;
                        wcnt_d   = CntW'(1);
                        state_d  = StHdr1;
                    end else begin
                        drop_cnt_d[bus.fifo_dout_qid] = drop_cnt_q[bus.fifo_dout_qid] + 32'd1;
                        state_d = StDropH;
                    end
                end
                StHdr1: state_d = StData;
                StData: begin
                    // The last reserved word is kept for EOP so a packet never exceeds its slot.
                    if (eop || (32'(wcnt_q) < MAX_PKT_WORDS - 1)) begin
                        do_write = 1'b1;
                        wcnt_d   = wcnt_q + 1'b1;
                    end
                    if (eop) begin
                        pkt_cnt_d[qid_q] = pkt_cnt_q[qid_q] + 32'd1;
                        state_d = parity_q ? StHdr0 : StPad;
                    end
                end
                StPad:   state_d = StHdr0;
                StDropH: state_d = StDrop;
                StDrop: begin
                    if (eop) begin
                        state_d = parity_q ? StHdr0 : StPad;
                    end
                end
                default: state_d = StHdr0;
            endcase
        end

        if (do_write) begin
            wr_valid_d     = 1'b1;
            wr_addr_d      = {wr_qid, ptr_q[wr_qid]};
            wr_data_d      = bus.fifo_dout;
            ptr_d[wr_qid]  = ptr_q[wr_qid] + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst_act) begin
            state_q    <= StHdr0;
            parity_q   <= 1'b0;
            qid_q      <= '0;
            wcnt_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                ptr_q[i]      <= '0;
                pkt_cnt_q[i]  <= '0;
                drop_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            parity_q   <= parity_d;
            qid_q      <= qid_d;
            wcnt_q     <= wcnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                ptr_q[i]      <= ptr_d[i];
                pkt_cnt_q[i]  <= pkt_cnt_d[i];
                drop_cnt_q[i] <= drop_cnt_d[i];
            end
        end
    end

    assign bus.mem_wr_valid = wr_valid_q;
    assign bus.mem_wr_addr  = wr_addr_q;
    assign bus.mem_wr_data  = wr_data_q;

    always_comb begin
        q_wr_ptr   = '0;
        q_pkt_cnt  = '0;
        q_drop_cnt = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            q_wr_ptr[i*QUEUE_ADDR_BITS +: QUEUE_ADDR_BITS] = ptr_q[i];
            q_pkt_cnt[i*32 +: 32]                          = pkt_cnt_q[i];
            q_drop_cnt[i*32 +: 32]                         = drop_cnt_q[i];
        end
    end
endmodule

// File: tb/tb_fifo_to_pcap_mem_writer.sv
// Bench for the pcap memory writer: packet-level reference model, FIFO emulator and a
// per-cycle compare process, driven by directed packet vectors.
module tb_fifo_to_pcap_mem_writer;
    localparam int QAB    = 8;
    localparam int REGION = 256;
    localparam int MAXW   = 128;

    typedef struct packed {
        logic [143:0] d;
        logic [1:0]   q;
    } fw_t;

    typedef struct packed {
        logic [9:0]   a;
        logic [143:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    logic sw_rst;
    logic [4*QAB-1:0] q_wr_ptr;
    logic [127:0]     q_pkt_cnt;
    logic [127:0]     q_drop_cnt;

    fifo_to_pcap_mem_writer_if #(
        .FIFO_DATA_WIDTH(144),
        .NUM_QUEUES_BITS(2),
        .QUEUE_ADDR_BITS(QAB)
    ) bus ();

    fifo_to_pcap_mem_writer #(
        .FIFO_DATA_WIDTH(144),
        .NUM_QUEUES     (4),
        .NUM_QUEUES_BITS(2),
        .QUEUE_ADDR_BITS(QAB),
        .MAX_PKT_WORDS  (MAXW)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rstn),
        .sw_rst     (sw_rst),
        .bus        (bus),
        .q_wr_ptr   (q_wr_ptr),
        .q_pkt_cnt  (q_pkt_cnt),
        .q_drop_cnt (q_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    fw_t        fq[$];
    wr_t        exp_wr[$];
    logic [9:0] acc_log[$];
    int         m_ptr[4];
    int         m_pkt[4];
    int         m_drop[4];
    bit         pop_pending = 1'b0;
    bit         gap_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    function automatic logic [143:0] mk_word(input bit eop, input int lane);
        logic [143:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w[9*i +: 8] = 8'($urandom);
            w[9*i+8]    = eop && (i == lane);
        end
        return w;
    endfunction

    // Packet-level model: decide fit/drop up front, then list the words that must land in memory.
    task automatic send_pkt(input int q, input int nbody, input bit complete);
        fw_t f;
        wr_t e;
        bit  fits;
        bit  last;
        int  written;
        fits = (REGION - m_ptr[q]) >= MAXW;
        if (!fits) m_drop[q]++;
        f.d = mk_word(1'b0, 0);
        f.q = 2'(q);
        fq.push_back(f);
        if (fits) begin
            e.a = {2'(q), 8'(m_ptr[q])};
            e.d = f.d;
            exp_wr.push_back(e);
            m_ptr[q]++;
        end
        f.d = '0;
        f.q = 2'(q + 1);
        fq.push_back(f);
        written = 1;
        for (int i = 1; i <= nbody; i++) begin
            last = complete && (i == nbody);
            f.d  = mk_word(last, int'($urandom_range(0, 15)));
            f.q  = 2'($urandom);
            fq.push_back(f);
            if (fits && (last || written < MAXW - 1)) begin
                e.a = {2'(q), 8'(m_ptr[q])};
                e.d = f.d;
                exp_wr.push_back(e);
                m_ptr[q]++;
                written++;
            end
        end
        if (complete) begin
            if (fits) m_pkt[q]++;
            if ((nbody % 2) == 1) begin
                f.d = '0;
                f.q = 2'($urandom);
                fq.push_back(f);
            end
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int t;
        t = 0;
        while ((fq.size() != 0 || exp_wr.size() != 0 || bus.mem_wr_valid !== 1'b0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL %s_drain: fifo %0d words, %0d writes outstanding, want 0", nm, fq.size(),
                     exp_wr.size());
        end
        @(negedge clk);
    endtask

    task automatic check_state(input string nm);
        for (int q = 0; q < 4; q++) begin
            chk($sformatf("%s_ptr%0d", nm, q), 64'(q_wr_ptr[q*QAB +: QAB]), 64'(m_ptr[q]));
            chk($sformatf("%s_pkt%0d", nm, q), 64'(q_pkt_cnt[q*32 +: 32]), 64'(m_pkt[q]));
            chk($sformatf("%s_drop%0d", nm, q), 64'(q_drop_cnt[q*32 +: 32]), 64'(m_drop[q]));
        end
    endtask

    // FIFO emulator: first-word-fall-through head of fq, optionally starved by a gap pattern.
    initial begin
        int cyc;
        cyc = 0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_dout     = '0;
        bus.fifo_dout_qid = '0;
        forever begin
            @(posedge clk);
            if (pop_pending && fq.size() != 0) fq.delete(0);
            #1;
            cyc++;
            if (fq.size() == 0 || (gap_mode && (cyc % 3 != 0))) begin
                bus.fifo_empty    = 1'b1;
                bus.fifo_dout     = '0;
                bus.fifo_dout_qid = '0;
            end else begin
                bus.fifo_empty    = 1'b0;
                bus.fifo_dout     = fq[0].d;
                bus.fifo_dout_qid = fq[0].q;
            end
        end
    end

    logic         prev_stall = 1'b0;
    logic [9:0]   prev_addr;
    logic [143:0] prev_data;

    always @(negedge clk) begin
        wr_t e;
        pop_pending = 1'b0;
        n_vec++;
        if (!rstn || sw_rst) begin
            if (bus.fifo_rd_en !== 1'b0) begin
                n_err++;
                $display("FAIL rd_en_in_reset: got %b, want 0", bus.fifo_rd_en);
            end
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty) begin
                n_err++;
                $display("FAIL rd_en_when_empty: got 1, want 0");
            end
            pop_pending = (bus.fifo_rd_en === 1'b1) && !bus.fifo_empty;
            if (prev_stall) begin
                n_vec++;
                if (bus.mem_wr_valid !== 1'b1 || bus.mem_wr_addr !== prev_addr ||
                    bus.mem_wr_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid %b addr %h, want valid 1 addr %h",
                             bus.mem_wr_valid, bus.mem_wr_addr, prev_addr);
                end
            end
            if (bus.mem_wr_valid === 1'b1 && bus.mem_wr_ready) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h, want no write", bus.mem_wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    if (bus.mem_wr_addr !== e.a || bus.mem_wr_data !== e.d) begin
                        n_err++;
                        $display("FAIL write: got addr %h data %h, want addr %h data %h",
                                 bus.mem_wr_addr, bus.mem_wr_data, e.a, e.d);
                    end
                end
                acc_log.push_back(bus.mem_wr_addr);
            end
            prev_stall = (bus.mem_wr_valid === 1'b1) && !bus.mem_wr_ready;
            prev_addr  = bus.mem_wr_addr;
            prev_data  = bus.mem_wr_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        int na;
        rstn             = 1'b0;
        sw_rst           = 1'b0;
        bus.mem_wr_ready = 1'b1;
        for (int q = 0; q < 4; q++) begin
            m_ptr[q]  = 0;
            m_pkt[q]  = 0;
            m_drop[q] = 0;
        end

        // Test 1: packet waits in the FIFO during reset and must not be popped early.
        send_pkt(1, 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.mem_wr_valid), 64'd0);
        chk("rst_ptr", 64'(q_wr_ptr), 64'd0);
        chk("rst_cnt", 64'(|{q_pkt_cnt, q_drop_cnt}), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        drain("t1", 100);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_addr%0d", i), 64'(acc_log[i]), 64'h100 + 64'(i));
        chk("t1_ptr1", 64'(q_wr_ptr[15:8]), 64'd4);
        chk("t1_pkt1", 64'(q_pkt_cnt[63:32]), 64'd1);

        // Test 2: EOP in a low half leaves a pad word; next header lands right after.
        send_pkt(2, 1, 1'b1);
        send_pkt(2, 2, 1'b1);
        drain("t2", 100);
        chk("t2_hdr_addr", 64'(acc_log[6]), 64'h202);
        chk("t2_ptr2", 64'(q_wr_ptr[23:16]), 64'd5);

        // Truncation: 130 body words keep 126 plus the EOP word.
        send_pkt(2, 130, 1'b1);
        drain("trunc", 400);
        chk("trunc_ptr2", 64'(q_wr_ptr[23:16]), 64'd133);
        chk("trunc_pkt2", 64'(q_pkt_cnt[95:64]), 64'd3);
        check_state("t2");

        // Test 3: backpressure mid-packet.
        base = acc_log.size();
        send_pkt(1, 8, 1'b1);
        t = 0;
        while (acc_log.size() < base + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t3_reach_stall", 64'(t < 200), 64'd1);
        @(posedge clk);
        #1 bus.mem_wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t3_rd_en%0d", k), 64'(bus.fifo_rd_en), 64'd0);
            chk($sformatf("t3_valid%0d", k), 64'(bus.mem_wr_valid), 64'd1);
        end
        @(posedge clk);
        #1 bus.mem_wr_ready = 1'b1;
        drain("t3", 100);
        chk("t3_ptr1", 64'(q_wr_ptr[15:8]), 64'd13);
        chk("t3_count", 64'(acc_log.size() - base), 64'd9);

        // Test 5: interleaved queues with a starving FIFO.
        gap_mode = 1'b1;
        send_pkt(0, 2, 1'b1);
        send_pkt(3, 3, 1'b1);
        send_pkt(0, 1, 1'b1);
        drain("t5", 400);
        gap_mode = 1'b0;
        chk("t5_pkt0", 64'(q_pkt_cnt[31:0]), 64'd2);
        chk("t5_pkt3", 64'(q_pkt_cnt[127:96]), 64'd1);
        chk("t5_ptr0", 64'(q_wr_ptr[7:0]), 64'd5);
        chk("t5_ptr3", 64'(q_wr_ptr[31:24]), 64'd4);

        // Test 4: fill q0 to 200, then a packet with only 56 free words is dropped.
        na = 127 - m_ptr[0];
        send_pkt(0, na, 1'b1);
        send_pkt(0, 71, 1'b1);
        drain("t4_fill", 600);
        chk("t4_ptr0_fill", 64'(q_wr_ptr[7:0]), 64'd200);
        send_pkt(0, 3, 1'b1);
        drain("t4_drop", 100);
        chk("t4_ptr0", 64'(q_wr_ptr[7:0]), 64'd200);
        chk("t4_drop0", 64'(q_drop_cnt[31:0]), 64'd1);
        chk("t4_pkt0", 64'(q_pkt_cnt[31:0]), 64'd4);
        check_state("t4");

        // Test 6: soft reset abandons a half-written packet.
        send_pkt(1, 2, 1'b0);
        drain("t6_partial", 100);
        @(posedge clk);
        #1 sw_rst = 1'b1;
        @(posedge clk);
        #1 sw_rst = 1'b0;
        for (int q = 0; q < 4; q++) begin
            m_ptr[q]  = 0;
            m_pkt[q]  = 0;
            m_drop[q] = 0;
        end
        @(negedge clk);
        chk("t6_valid", 64'(bus.mem_wr_valid), 64'd0);
        chk("t6_ptr", 64'(q_wr_ptr), 64'd0);
        chk("t6_cnt", 64'(|{q_pkt_cnt, q_drop_cnt}), 64'd0);
        base = acc_log.size();
        send_pkt(1, 2, 1'b1);
        drain("t6", 100);
        chk("t6_hdr_addr", 64'(acc_log[base]), 64'h100);
        chk("t6_ptr1", 64'(q_wr_ptr[15:8]), 64'd3);
        chk("t6_pkt1", 64'(q_pkt_cnt[63:32]), 64'd1);
        check_state("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
